// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types, default timing constants and bit helpers for the
// PS/2 host-to-device transmitter.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    REQ     = 3'd2,
    XFER    = 3'd3,
    ACK     = 3'd4
  } ps2_tx_state_e;

  // Defaults derived from a 50 MHz system clock.
  localparam int unsigned PS2_CLK_HZ         = 32'd50_000_000;
  localparam int unsigned PS2_INHIBIT_CYCLES = 32'd6000;     // 120 us
  localparam int unsigned PS2_START_TIMEOUT  = 32'd750000;   // 15 ms
  localparam int unsigned PS2_PACKET_TIMEOUT = 32'd100000;   // 2 ms

  // Shared counter width; every timing constant must fit in it.
  localparam int unsigned PS2_CNT_W   = 32'd20;
  localparam int unsigned PS2_CNT_MAX = 32'd1048575;

  // Odd parity: the returned bit makes the total count of ones odd.
  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  // Line level of frame position idx: 0-7 data LSB first, 8 parity, 9+ stop.
  function automatic logic ps2_frame_bit(input logic [7:0] data,
                                         input logic       par,
                                         input logic [3:0] idx);
    logic b;
    if (idx < 4'd8) begin
      b = data[idx[2:0]];
    end else if (idx == 4'd8) begin
      b = par;
    end else begin
      b = 1'b1;
    end
    return b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake between the keyboard controller
// (master) and the PS/2 host transmitter (slave).
interface ps2_host_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_busy,
    input  tx_done,
    input  tx_error
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_busy,
    output tx_done,
    output tx_error
  );

endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: two-flop synchronizer for an asynchronous PS/2 pad plus a
// falling-edge detector on the synchronized value. Flops reset to 1 because
// an idle open-drain line floats high.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic in_async,
  output logic sync,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  // Next-state for the synchronizer chain and the edge-history flop.
  always_comb begin
    s1_d   = in_async;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  // Register the chain; idle-high after reset so no spurious edge appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign sync = s2_q;
  assign fall = prev_q & ~s2_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter. Drives the
// open-drain PS2_CLK/PS2_DAT pair through low-side output enables only.
// Optional feature macro: PS2_TX_TIMEOUT_EN enables the start and packet
// timeouts; without it REQ/XFER/ACK wait indefinitely and tx_error only
// reports a NACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ         = PS2_CLK_HZ,
  parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int unsigned START_TIMEOUT  = PS2_START_TIMEOUT,
  parameter int unsigned PACKET_TIMEOUT = PS2_PACKET_TIMEOUT
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk_in,
  input  logic         ps2_dat_in,
  output logic         ps2_clk_oe,
  output logic         ps2_dat_oe
);

  // Timing constants must fit the shared 20-bit counter.
  if (CLK_HZ == 32'd0 || INHIBIT_CYCLES > PS2_CNT_MAX ||
      START_TIMEOUT > PS2_CNT_MAX || PACKET_TIMEOUT > PS2_CNT_MAX) begin : g_cnt_range
    $error("ps2_host_tx: timing constant exceeds the 20-bit counter range");
  end

  localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYCLES - 32'd1);

  logic clk_sync_s, clk_fall_s;
  logic dat_sync_s, dat_fall_unused_s;

  ps2_line_sync u_clk_sync (
    .clk      (CLOCK_50),
    .rst_n    (reset),
    .in_async (ps2_clk_in),
    .sync     (clk_sync_s),
    .fall     (clk_fall_s)
  );

  ps2_line_sync u_dat_sync (
    .clk      (CLOCK_50),
    .rst_n    (reset),
    .in_async (ps2_dat_in),
    .sync     (dat_sync_s),
    .fall     (dat_fall_unused_s)
  );

  ps2_tx_state_e state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [19:0]   cnt_q, cnt_d;
  logic          clk_oe_q, clk_oe_d;
  logic          dat_oe_q, dat_oe_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          timeout_s;
  logic [19:0]   cnt_run_s;

`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [19:0] START_LAST  = 20'(START_TIMEOUT - 32'd1);
  localparam logic [19:0] PACKET_LAST = 20'(PACKET_TIMEOUT - 32'd1);

  // Timer advances while waiting on the device; flag the per-phase limit.
  always_comb begin
    cnt_run_s = cnt_q + 20'd1;
    timeout_s = 1'b0;
    if (state_q == REQ) begin
      timeout_s = (cnt_q >= START_LAST);
    end else if (state_q == XFER || state_q == ACK) begin
      timeout_s = (cnt_q >= PACKET_LAST);
    end else begin
      timeout_s = 1'b0;
    end
  end
`else
  // Without timeouts the timer stays frozen and never expires.
  always_comb begin
    cnt_run_s = cnt_q;
    timeout_s = 1'b0;
  end
`endif

  // Transmit sequencing: next state, line enables and handshake outputs.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_d     = par_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        ready_d  = 1'b1;
        if (tx.tx_valid && ready_q) begin
          data_d   = tx.tx_data;
          par_d    = ps2_odd_parity(tx.tx_data);
          cnt_d    = 20'd0;
          clk_oe_d = 1'b1;
          ready_d  = 1'b0;
          state_d  = INHIBIT;
        end else begin
          state_d  = IDLE;
        end
      end

      // Hold clock low; device edges are ignored here.
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          clk_oe_d  = 1'b0;
          dat_oe_d  = 1'b1;
          bit_idx_d = 4'd0;
          cnt_d     = 20'd0;
          state_d   = REQ;
        end else begin
          cnt_d     = cnt_q + 20'd1;
        end
      end

      // Start bit on the line; wait for the device to begin clocking.
      REQ: begin
        if (timeout_s) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          ready_d  = 1'b1;
          err_d    = 1'b1;
          state_d  = IDLE;
        end else if (clk_fall_s) begin
          bit_idx_d = 4'd0;
          dat_oe_d  = ~ps2_frame_bit(data_q, par_q, 4'd0);
          cnt_d     = 20'd0;
          state_d   = XFER;
        end else begin
          cnt_d     = cnt_run_s;
        end
      end

      // Present the next frame bit on each device falling edge.
      XFER: begin
        if (timeout_s) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          ready_d  = 1'b1;
          err_d    = 1'b1;
          state_d  = IDLE;
        end else if (clk_fall_s && bit_idx_q == 4'd9) begin
          dat_oe_d = 1'b0;
          cnt_d    = cnt_run_s;
          state_d  = ACK;
        end else if (clk_fall_s) begin
          bit_idx_d = bit_idx_q + 4'd1;
          dat_oe_d  = ~ps2_frame_bit(data_q, par_q, bit_idx_q + 4'd1);
          cnt_d     = cnt_run_s;
        end else begin
          cnt_d     = cnt_run_s;
        end
      end

      // Device drives DAT low to acknowledge; high means NACK.
      ACK: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        ready_d  = 1'b1;
        state_d  = IDLE;
        if (timeout_s) begin
          err_d  = 1'b1;
        end else if (!dat_sync_s) begin
          done_d = 1'b1;
        end else begin
          err_d  = 1'b1;
        end
      end

      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        ready_d  = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset releases both lines at once.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      data_q    <= 8'h00;
      par_q     <= 1'b0;
      bit_idx_q <= 4'd0;
      cnt_q     <= 20'd0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_q     <= par_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_dat_oe  = dat_oe_q;
  assign tx.tx_ready = ready_q;
  assign tx.tx_busy  = ~ready_q;
  assign tx.tx_done  = done_q;
  assign tx.tx_error = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a device-side
// open-drain bus model (clock half-period H cycles).
module tb_ps2_host_tx;

  localparam int H = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic ps2_clk_in, ps2_dat_in;
  logic ps2_clk_oe, ps2_dat_oe;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int clkoe_cnt = 0;

  ps2_host_tx_if tx_if ();

  // Open-drain wired-AND of host and device pull-downs.
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .START_TIMEOUT  (3000),
    .PACKET_TIMEOUT (20000)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (rst_n),
    .tx         (tx_if),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #10 clk = ~clk;

  // Pulse and clock-low-cycle counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (tx_if.tx_done)  done_cnt++;
    if (tx_if.tx_error) err_cnt++;
    if (ps2_clk_oe)     clkoe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_if.tx_data  = d;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
  endtask

  // Device model: wait for the start-bit request, then generate n clock pulses,
  // sampling DAT at each rising edge; optionally ack on the 11th pulse.
  task automatic dev_clock(input int n, input logic ack,
                           output logic [10:0] fr, output logic ok);
    int w;
    fr = 11'd0;
    ok = 1'b0;
    w  = 0;
    while (!(ps2_dat_oe && !ps2_clk_oe) && w < 10000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 10000) return;
    repeat (10) @(negedge clk);
    fr[0] = ps2_dat_in;
    for (int i = 1; i <= n; i++) begin
      if (i == 11 && ack) dev_dat_low = 1'b1;
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      if (i <= 10) fr[i] = ps2_dat_in;
      repeat (H) @(negedge clk);
    end
    dev_dat_low = 1'b0;
    ok = 1'b1;
  endtask

  initial begin
    logic [10:0] fr;
    logic        ok;
    int          d0, e0, c0, n;

    rst_n          = 1'b0;
    tx_if.tx_data  = 8'h00;
    tx_if.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready",  32'(tx_if.tx_ready), 32'd1);
    chk("rst_busy",   32'(tx_if.tx_busy),  32'd0);
    chk("rst_done",   32'(tx_if.tx_done),  32'd0);
    chk("rst_error",  32'(tx_if.tx_error), 32'd0);
    chk("rst_clk_oe", 32'(ps2_clk_oe),     32'd0);
    chk("rst_dat_oe", 32'(ps2_dat_oe),     32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0xED with ack; clk_oe high one cycle after the accept edge.
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    chk("ed_clk_oe_rise", 32'(ps2_clk_oe),    32'd1);
    chk("ed_busy",        32'(tx_if.tx_busy), 32'd1);
    dev_clock(11, 1'b1, fr, ok);
    chk("ed_req_seen", 32'(ok), 32'd1);
    chk("ed_frame",    32'(fr), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
    repeat (5) @(negedge clk);
    chk("ed_done", 32'(done_cnt - d0),   32'd1);
    chk("ed_err",  32'(err_cnt - e0),    32'd0);
    chk("ed_ready", 32'(tx_if.tx_ready), 32'd1);

    // 0xF4 with ack; clock inhibit lasts exactly 6000 cycles.
    d0 = done_cnt; c0 = clkoe_cnt;
    send(8'hF4);
    dev_clock(11, 1'b1, fr, ok);
    chk("f4_frame",   32'(fr), 32'({1'b1, 1'b0, 8'hF4, 1'b0}));
    repeat (5) @(negedge clk);
    chk("f4_done",    32'(done_cnt - d0),  32'd1);
    chk("f4_inhibit", 32'(clkoe_cnt - c0), 32'd6000);

    // 0x55 with the device leaving DAT high on the 11th clock: NACK.
    d0 = done_cnt; e0 = err_cnt;
    send(8'h55);
    dev_clock(11, 1'b0, fr, ok);
    chk("nack_frame", 32'(fr), 32'({1'b1, 1'b1, 8'h55, 1'b0}));
    repeat (5) @(negedge clk);
    chk("nack_err",   32'(err_cnt - e0),   32'd1);
    chk("nack_done",  32'(done_cnt - d0),  32'd0);
    chk("nack_ready", 32'(tx_if.tx_ready), 32'd1);

    // Device never clocks.
    e0 = err_cnt;
    send(8'hF4);
    n = 0;
    while (!(ps2_dat_oe && !ps2_clk_oe) && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("to_req_seen", 32'(n < 10000), 32'd1);
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    while (!tx_if.tx_error && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("to_start_cycles", 32'(n),          32'd3000);
    chk("to_clk_oe",       32'(ps2_clk_oe), 32'd0);
    chk("to_dat_oe",       32'(ps2_dat_oe), 32'd0);
    chk("to_ready",        32'(tx_if.tx_ready), 32'd1);
`else
    repeat (20000) @(negedge clk);
    chk("wait_dat_oe", 32'(ps2_dat_oe),    32'd1);
    chk("wait_clk_oe", 32'(ps2_clk_oe),    32'd0);
    chk("wait_busy",   32'(tx_if.tx_busy), 32'd1);
    chk("wait_no_err", 32'(err_cnt - e0),  32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif

    // Reset mid-frame after data bits 0-3; bit 4 of 0xED (0) is on the line.
    send(8'hED);
    dev_clock(5, 1'b0, fr, ok);
    chk("mid_dat_oe", 32'(ps2_dat_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_clk_oe", 32'(ps2_clk_oe),     32'd0);
    chk("mid_rst_dat_oe", 32'(ps2_dat_oe),     32'd0);
    chk("mid_rst_ready",  32'(tx_if.tx_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    send(8'hFF);
    dev_clock(11, 1'b1, fr, ok);
    chk("ff_frame", 32'(fr), 32'({1'b1, 1'b1, 8'hFF, 1'b0}));
    repeat (5) @(negedge clk);
    chk("ff_done",  32'(done_cnt - d0), 32'd1);

    // 0xAA request while busy is dropped.
    d0 = done_cnt;
    send(8'hED);
    repeat (50) @(negedge clk);
    tx_if.tx_data  = 8'hAA;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    chk("ign_busy", 32'(tx_if.tx_busy), 32'd1);
    dev_clock(11, 1'b1, fr, ok);
    chk("ign_frame", 32'(fr), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
    repeat (100) @(negedge clk);
    chk("ign_done",   32'(done_cnt - d0), 32'd1);
    chk("ign_idle",   32'(tx_if.tx_busy), 32'd0);
    chk("ign_clk_oe", 32'(ps2_clk_oe),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

PS/2 host-to-device transmitter for the keyboard interface: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard over the open-drain PS2_CLK/PS2_DAT pair. It sits beside the existing keyboard receive path. It drives the lines only through low-side output enables, so the top level ties them to the shared tristate pads. While busy it asserts `tx_busy` so the receive path can ignore host-generated line activity.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency; documentation only, used to derive the defaults below.
- `INHIBIT_CYCLES`, 6000: length of the host clock-low request (120 us at 50 MHz).
- `START_TIMEOUT`, 750000: maximum wait from request to the first device falling edge (15 ms).
- `PACKET_TIMEOUT`, 100000: maximum wait from the first device edge to the ack (2 ms).
- `CLOCK_50` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `tx_data` in 8: byte to send; sampled on accept.
- `tx_valid` in 1: send request.
- `tx_ready` out 1: high in IDLE only; accept = `tx_valid & tx_ready`.
- `tx_busy` out 1: equals `~tx_ready`.
- `tx_done` out 1: one-cycle pulse when the device acks.
- `tx_error` out 1: one-cycle pulse on NACK or timeout.
- `ps2_clk_in` in 1: raw PS2_CLK pad value (asynchronous).
- `ps2_dat_in` in 1: raw PS2_DAT pad value (asynchronous).
- `ps2_clk_oe` out 1: 1 pulls PS2_CLK low; 0 releases it.
- `ps2_dat_oe` out 1: 1 pulls PS2_DAT low; 0 releases it.

## Operation
- Both pad inputs pass through a 2-FF synchronizer. A falling edge (`fall`) is detected when the previous synced value is 1 and the current one is 0.
- **IDLE:** both OEs are 0 and `tx_ready` is 1. On accept, latch `tx_data`, compute odd parity (`~^tx_data`), clear the counter, and go to INHIBIT.
- **INHIBIT:** `ps2_clk_oe` = 1 and `ps2_dat_oe` = 0 for exactly `INHIBIT_CYCLES` cycles. Any `fall` is ignored. Then go to REQ.
- **REQ:** `ps2_dat_oe` = 1 (start bit 0) and `ps2_clk_oe` = 0. Set bit index = 0 and clear the timer. On `fall`, go to XFER.
- **XFER:** on each `fall`, advance the bit index and present the next bit:
  - Bits 0–7: data, LSB first. `ps2_dat_oe = ~bit`.
  - Bit 8: the parity bit.
  - Bit 9: stop; release DAT (`ps2_dat_oe` = 0).
  - The following `fall` goes to ACK.
- **ACK:** sample synced DAT on the cycle after the `fall`. A value of 0 gives a `tx_done` pulse; 1 gives a `tx_error` pulse. Either way return to IDLE.
- **Timeout:** in REQ, if the timer reaches `START_TIMEOUT`, or in XFER/ACK if it reaches `PACKET_TIMEOUT`:
  - pulse `tx_error`, release both OEs, and return to IDLE;
  - the timer resets on entry to XFER only, not on every edge.
- `tx_valid` while busy is ignored; the request is not queued.
- Counter widths are 20 bits; the timeout constants must fit, and elaboration fails if any exceeds 2^20−1.

## Timing
- Reset values: `ps2_clk_oe` = 0, `ps2_dat_oe` = 0, `tx_ready` = 1, `tx_busy` = 0, `tx_done` = 0, `tx_error` = 0, state = IDLE.
- Reset takes effect immediately, even mid-frame. The lines release with no clock required.
- Accept at edge N: `ps2_clk_oe` rises at N+1.
- REQ entry: `ps2_dat_oe` = 1 and `ps2_clk_oe` = 0 in the same cycle.
- Pad falling edge to updated `ps2_dat_oe`: 3 cycles (2 sync + 1 edge register). This is far inside the device's ≥30 us clock-low half-period.
- `tx_done`/`tx_error`: asserted the cycle after the 11th `fall` (or the timeout cycle), for 1 cycle. `tx_ready` returns to 1 in that same cycle.
- A new accept is possible the cycle `tx_ready` reads 1.

## Configuration
- `PS2_TX_TIMEOUT_EN` defined: both timeouts are active as described above.
- Not defined:
  - the timers and timeout checks are compiled out;
  - REQ, XFER and ACK wait indefinitely;
  - `tx_error` fires only on NACK.

## Structure
- Package `ps2_pkg` holds:
  - the state enum (IDLE, INHIBIT, REQ, XFER, ACK);
  - default timing constants;
  - the odd-parity function.
- One sub-module, `ps2_line_sync`: a 2-FF synchronizer plus falling-edge detector, instantiated once for CLK and once for DAT.
- A device-side bus model is bench-only.

## Test plan
- Send 0xED with the device model acking → DAT bits 1,0,1,1,0,1,1,1, parity 1, stop released; `tx_done` pulses once.
- Send 0xF4 → data 0,0,1,0,1,1,1,1, parity 0; `tx_done` pulses; `ps2_clk_oe` was high for exactly 6000 cycles.
- Device leaves DAT high on the 11th clock → `tx_error` pulses, no `tx_done`, `tx_ready` = 1.
- With `PS2_TX_TIMEOUT_EN`, the device never clocks → `tx_error` pulses at REQ entry + 750000 cycles; both OEs are 0. Without the macro, the block is still in REQ after 1,000,000 cycles.
- Assert `reset` after the 4th data bit → both OEs are 0 and `tx_ready` = 1 immediately. A subsequent 0xFF send completes normally.
- Pulse `tx_valid` with 0xAA during an 0xED send → ignored; only 0xED appears on the bus.
